// File: rtl/array_pkg.sv
// array_pkg: shared defaults, occupancy encoding and the shift/saturate helper used by the
// array_drain output stage.
//   D_W_ACC_DEF / N_DEF : default accumulator width and lane count
//   occ_e               : buffer occupancy (enum value equals the number of stored vectors)
//   sat_shift()         : arithmetic right shift followed by signed clipping to out_w bits
package array_pkg;

  localparam int unsigned D_W_ACC_DEF = 16;
  localparam int unsigned N_DEF       = 3;
  // Working width of the helper; accumulator and output widths must not exceed it.
  localparam int unsigned SAT_W       = 32;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } occ_e;

  typedef struct packed {
    logic signed [SAT_W-1:0] value;
    logic                    sat;
  } sat_res_t;

  function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] value,
                                         input int unsigned             shift,
                                         input int unsigned             out_w);
    sat_res_t                res;
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    shifted = value >>> shift;
    hi      = $signed((SAT_W'(1) << (out_w - 1)) - SAT_W'(1));
    lo      = ~hi;  // -2^(out_w-1)
    res.sat = 1'b1;
    if (shifted > hi) begin
      res.value = hi;
    end else if (shifted < lo) begin
      res.value = lo;
    end else begin
      res.value = shifted;
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/array_sat_narrow.sv
// array_sat_narrow: combinational narrowing of one signed accumulator value.
//   value_i : signed D_W_ACC-bit accumulator
//   value_o : signed OUT_W-bit result of (value_i >>> SHIFT), clipped to the OUT_W range
//   sat_o   : high when clipping was applied
module array_sat_narrow
  import array_pkg::*;
#(
  parameter int unsigned D_W_ACC = D_W_ACC_DEF,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT   = 0
) (
  input  logic signed [D_W_ACC-1:0] value_i,
  output logic signed [OUT_W-1:0]   value_o,
  output logic                      sat_o
);

  sat_res_t res;
  logic     unused_hi;

  always_comb begin
    // Size cast of a signed operand sign-extends into the helper's working width.
    res     = sat_shift(SAT_W'(value_i), SHIFT, OUT_W);
    value_o = res.value[OUT_W-1:0];
    sat_o   = res.sat;
  end

  // After clipping the upper bits are pure sign copies.
  assign unused_hi = ^res.value[SAT_W-1:OUT_W];

endmodule

// File: rtl/array_drain.sv
// array_drain: two-entry snapshot buffer behind the N-lane MAC array, streamed out one lane
// per beat with shift and saturation.
//   clk, rst       : clock, synchronous active-high reset
//   capture/result : snapshot request and the N accumulator values
//   m_data/m_valid/m_ready/m_lane/m_last/m_sat : valid/ready output stream
//   drop           : one-cycle pulse after a capture was refused (buffer full)
module array_drain
  import array_pkg::*;
#(
  parameter int unsigned D_W_ACC = D_W_ACC_DEF,
  parameter int unsigned N       = N_DEF,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT   = 0,
  localparam int unsigned LW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      capture,
  input  logic signed [D_W_ACC-1:0] result [N],
  output logic signed [OUT_W-1:0]   m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LW-1:0]             m_lane,
  output logic                      m_last,
  output logic                      m_sat,
  output logic                      drop
);

  localparam logic [LW-1:0] LastLane = LW'(N - 1);

  logic signed [D_W_ACC-1:0] slot_q [2][N];
  logic signed [D_W_ACC-1:0] slot_d [2][N];
  occ_e                      state_q, state_d;
  logic                      wp_q, wp_d;
  logic                      rp_q, rp_d;
  logic [LW-1:0]             ln_q, ln_d;
  logic                      drop_q, drop_d;

  logic beat;
  logic final_beat;
  logic accept;

  assign m_valid    = (state_q != StEmpty);
  assign beat       = m_valid & m_ready;
  assign final_beat = beat & (ln_q == LastLane);
  // A full buffer still takes a capture when the head vector retires this cycle: the freed
  // slot is the one wp already points at.
  assign accept     = capture & ((state_q != StTwo) | final_beat);

  always_comb begin
    slot_d = slot_q;
    if (accept) begin
      slot_d[wp_q] = result;
    end
    wp_d   = wp_q ^ accept;
    rp_d   = rp_q ^ final_beat;
    drop_d = capture & ~accept;

    ln_d = ln_q;
    if (final_beat) begin
      ln_d = '0;
    end else if (beat) begin
      ln_d = ln_q + LW'(1);
    end

    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StOne;
      StOne: begin
        if (accept && !final_beat)      state_d = StTwo;
        else if (final_beat && !accept) state_d = StEmpty;
      end
      StTwo:   if (final_beat && !accept) state_d = StOne;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '{default: '0};
      state_q <= StEmpty;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      ln_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      ln_q    <= ln_d;
      drop_q  <= drop_d;
    end
  end

  array_sat_narrow #(
    .D_W_ACC (D_W_ACC),
    .OUT_W   (OUT_W),
    .SHIFT   (SHIFT)
  ) u_sat (
    .value_i (slot_q[rp_q][ln_q]),
    .value_o (m_data),
    .sat_o   (m_sat)
  );

  assign m_lane = ln_q;
  assign m_last = (ln_q == LastLane);
  assign drop   = drop_q;

endmodule

// File: tb/tb_array_drain.sv
module tb_array_drain;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int OW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 capture;
  logic                 m_ready;
  logic signed [DW-1:0] result [N];

  logic signed [OW-1:0] d0, d3;
  logic                 v0, v3, last0, last3, sat0, sat3, drop0, drop3;
  logic [1:0]           lane0, lane3;

  always #5 clk = ~clk;

  array_drain #(.D_W_ACC(DW), .N(N), .OUT_W(OW), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .capture(capture), .result(result),
    .m_data(d0), .m_valid(v0), .m_ready(m_ready), .m_lane(lane0),
    .m_last(last0), .m_sat(sat0), .drop(drop0)
  );

  array_drain #(.D_W_ACC(DW), .N(N), .OUT_W(OW), .SHIFT(3)) dut3 (
    .clk(clk), .rst(rst), .capture(capture), .result(result),
    .m_data(d3), .m_valid(v3), .m_ready(m_ready), .m_lane(lane3),
    .m_last(last3), .m_sat(sat3), .drop(drop3)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO of captured vectors (capacity 2) plus the lane being streamed.
  typedef int vec_t [N];
  vec_t mq[$];
  int   m_lane_q = 0;
  bit   m_drop   = 1'b0;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_sat(input int v, input int sh, output bit s);
    int t;
    int hi;
    int lo;
    t  = v >>> sh;
    hi = (1 << (OW - 1)) - 1;
    lo = -(1 << (OW - 1));
    s  = 1'b0;
    if (t > hi) begin
      t = hi;
      s = 1'b1;
    end else if (t < lo) begin
      t = lo;
      s = 1'b1;
    end
    return t;
  endfunction

  task automatic set_res(input int a, input int b, input int c);
    result[0] = DW'(a);
    result[1] = DW'(b);
    result[2] = DW'(c);
  endtask

  task automatic set_rand();
    for (int i = 0; i < N; i++) begin
      // Mix of small values and full-range values to exercise both paths.
      if ($urandom_range(0, 1) == 0) result[i] = DW'($signed($urandom_range(0, 400)) - 200);
      else                           result[i] = DW'($urandom);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle against the model, then advance
  // the model by the clock edge that ends this cycle.
  task automatic step(input bit cap, input bit rdy, input bit rs);
    bit   exp_valid;
    bit   hs;
    bit   fin;
    bit   acc;
    bit   s;
    int   e;
    vec_t v;
    capture = cap;
    m_ready = rdy;
    rst     = rs;
    @(negedge clk);
    exp_valid = (mq.size() != 0);
    check_eq("valid_s0", v0, exp_valid);
    check_eq("valid_s3", v3, exp_valid);
    check_eq("drop_s0", drop0, m_drop);
    check_eq("drop_s3", drop3, m_drop);
    check_eq("lane_s0", lane0, m_lane_q);
    check_eq("lane_s3", lane3, m_lane_q);
    check_eq("last_s0", last0, (m_lane_q == N - 1));
    check_eq("last_s3", last3, (m_lane_q == N - 1));
    if (exp_valid) begin
      e = ref_sat(mq[0][m_lane_q], 0, s);
      check_eq("data_s0", d0, e);
      check_eq("sat_s0", sat0, s);
      e = ref_sat(mq[0][m_lane_q], 3, s);
      check_eq("data_s3", d3, e);
      check_eq("sat_s3", sat3, s);
    end
    if (rs) begin
      mq.delete();
      m_lane_q = 0;
      m_drop   = 1'b0;
    end else begin
      hs     = exp_valid && rdy;
      fin    = hs && (m_lane_q == N - 1);
      acc    = cap && ((mq.size() < 2) || fin);
      m_drop = cap && !acc;
      if (fin) begin
        void'(mq.pop_front());
        m_lane_q = 0;
      end else if (hs) begin
        m_lane_q++;
      end
      if (acc) begin
        for (int i = 0; i < N; i++) v[i] = int'(result[i]);
        mq.push_back(v);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    capture = 1'b0;
    m_ready = 1'b0;
    set_res(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", v0, 0);
    check_eq("rst_lane", lane0, 0);
    check_eq("rst_last", last0, 0);
    check_eq("rst_sat", sat0, 0);
    check_eq("rst_drop", drop0, 0);
    check_eq("rst_data", d0, 0);
    check_eq("rst_data3", d3, 0);

    // Single vector
    set_res(5, -7, 100);
    step(1, 1, 0);
    repeat (4) step(0, 1, 0);

    // Saturation and shift
    set_res(300, -300, 1024);
    step(1, 1, 0);
    repeat (4) step(0, 1, 0);

    // Backpressure mid-vector
    set_rand();
    step(1, 1, 0);
    step(0, 1, 0);
    repeat (4) step(0, 0, 0);
    repeat (4) step(0, 1, 0);

    // Full buffer, refused capture, then capture coinciding with a final beat at cnt 2
    set_res(11, 22, 33);
    step(1, 0, 0);
    set_res(-44, 55, -66);
    step(1, 0, 0);
    set_res(77, 88, 99);
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    set_res(1000, -1000, 7);
    step(1, 1, 0);
    repeat (8) step(0, 1, 0);

    // Reset mid-stream during lane 1
    set_rand();
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 0);
    set_res(-1, 2, -3);
    step(1, 1, 0);
    repeat (4) step(0, 1, 0);

    // Sustained capture every N cycles with m_ready high
    for (int k = 0; k < 10; k++) begin
      set_rand();
      step(1, 1, 0);
      step(0, 1, 0);
      step(0, 1, 0);
    end
    repeat (4) step(0, 1, 0);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      set_rand();
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
